// File: rtl/tdc_ram_pkg.sv
// Shared constants and FSM encodings for the DPRAM page reader.
// Page layout: word HDR_ADDR holds the payload length, payload follows at 1..N.
package tdc_ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int HDR_ADDR   = 0;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t RD_HDR   = 3'd1;
    localparam state_t WAIT_HDR = 3'd2;
    localparam state_t STREAM   = 3'd3;
    localparam state_t DONE_HS  = 3'd4;

endpackage

// File: rtl/tdc_skid_fifo.sv
// Registered output stage plus a 2-entry skid buffer for DPRAM read data.
// credit tells the reader whether one more read can be launched without overflow.
module tdc_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic [1:0]        inflight,
    input  logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              credit,
    output logic              last_accept
);

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // ready are both 1; while out_valid=1 and ready=0 the word is held unchanged.
    logic [DATA_W:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      cnt;
    logic            pop;
    logic            load_out;
    logic            buf_rd;
    logic            buf_wr;
    logic [2:0]      occupancy;

    assign pop         = out_valid & ready;
    assign last_accept = pop & out_last;
    assign load_out    = !out_valid || pop;
    assign buf_rd      = load_out && (cnt != 2'd0);
    assign buf_wr      = push && !(load_out && (cnt == 2'd0));

    // Words held plus reads still on their way must never exceed the three slots.
    assign occupancy = 3'(out_valid) + 3'(cnt) + 3'(inflight);
    assign credit    = (occupancy - 3'(pop)) < 3'd3;

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            if (load_out) begin
                if (cnt != 2'd0) begin
                    {out_last, out_data} <= mem[rd_ptr];
                    out_valid            <= 1'b1;
                end else if (push) begin
                    out_data  <= push_data;
                    out_last  <= push_last;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
            if (buf_wr) begin
                wr_ptr <= ~wr_ptr;
            end
            if (buf_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, buf_wr} - {1'b0, buf_rd};
        end
    end

endmodule

// File: rtl/tdc_page_reader.sv
// Reads a filled DPRAM page through the second port, streams its payload and
// returns handshakePC so the writer can reuse the page.
module tdc_page_reader
    import tdc_ram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SYSCLK,
    input  logic              RESET_N,
    input  logic              handshakeFPGA,
    output logic              handshakePC,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [31:0]       page_count,
    output logic              err_len,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] N_MAX = '1;

    logic [SYNC_STAGES-1:0] hs_sync;
    logic                   hs_synced;
    state_t                 state;
    logic [ADDR_W-1:0]      n_len;
    logic [ADDR_W:0]        issue_idx;
    logic                   pend;
    logic                   pend_last;
    logic [1:0]             inflight;
    logic                   credit;
    logic                   last_accept;
    logic [ADDR_W:0]        hdr_len;
    logic [ADDR_W-1:0]      hdr_n;
    logic                   hdr_clamp;
    logic                   hdr_unused;
    logic [ADDR_W-1:0]      read_lim;
    logic                   issue_ok;

    assign hs_synced = hs_sync[SYNC_STAGES-1];
    assign dbg_state = state;

    // The length field is one bit wider than the address so oversize headers are detectable.
    assign hdr_len    = ram_rdata[ADDR_W:0];
    assign hdr_unused = ^ram_rdata[DATA_W-1:ADDR_W+1];
    assign hdr_clamp  = hdr_len > {1'b0, N_MAX};
    assign hdr_n      = hdr_clamp ? N_MAX : hdr_len[ADDR_W-1:0];

    assign read_lim = (state == WAIT_HDR) ? hdr_n : n_len;
    assign issue_ok = credit && (issue_idx <= {1'b0, read_lim});
    assign inflight = {1'b0, pend} + {1'b0, ram_re};

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_sync <= '0;
        end else begin
            hs_sync[0] <= handshakeFPGA;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                hs_sync[i] <= hs_sync[i-1];
            end
        end
    end

    // Word 1 is fetched speculatively while the header is in flight; pend drops it if N=0.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            handshakePC <= 1'b0;
            ram_re      <= 1'b0;
            ram_addr    <= '0;
            page_count  <= '0;
            err_len     <= 1'b0;
            n_len       <= '0;
            issue_idx   <= '0;
            pend        <= 1'b0;
            pend_last   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    ram_re      <= 1'b0;
                    pend        <= 1'b0;
                    handshakePC <= 1'b0;
                    if (hs_synced) begin
                        state    <= RD_HDR;
                        ram_re   <= 1'b1;
                        ram_addr <= ADDR_W'(HDR_ADDR);
                    end
                end
                RD_HDR: begin
                    state     <= WAIT_HDR;
                    ram_re    <= 1'b1;
                    ram_addr  <= ADDR_W'(1);
                    issue_idx <= (ADDR_W+1)'(2);
                end
                WAIT_HDR: begin
                    n_len     <= hdr_n;
                    err_len   <= hdr_clamp;
                    pend      <= (hdr_n != '0);
                    pend_last <= (hdr_n == ADDR_W'(1));
                    if (hdr_n == '0) begin
                        state       <= DONE_HS;
                        handshakePC <= 1'b1;
                        page_count  <= page_count + 32'd1;
                        ram_re      <= 1'b0;
                    end else begin
                        state <= STREAM;
                        if (issue_ok) begin
                            ram_re    <= 1'b1;
                            ram_addr  <= issue_idx[ADDR_W-1:0];
                            issue_idx <= issue_idx + 1'b1;
                        end else begin
                            ram_re <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    pend      <= ram_re;
                    pend_last <= (ram_addr == n_len);
                    if (issue_ok) begin
                        ram_re    <= 1'b1;
                        ram_addr  <= issue_idx[ADDR_W-1:0];
                        issue_idx <= issue_idx + 1'b1;
                    end else begin
                        ram_re <= 1'b0;
                    end
                    if (last_accept) begin
                        state       <= DONE_HS;
                        handshakePC <= 1'b1;
                        page_count  <= page_count + 32'd1;
                    end
                end
                DONE_HS: begin
                    ram_re <= 1'b0;
                    pend   <= 1'b0;
                    if (!hs_synced) begin
                        state       <= IDLE;
                        handshakePC <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    tdc_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (SYSCLK),
        .rst_n       (RESET_N),
        .push        (pend),
        .push_data   (ram_rdata),
        .push_last   (pend_last),
        .inflight    (inflight),
        .ready       (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .credit      (credit),
        .last_accept (last_accept)
    );

endmodule

// File: tb/tb_tdc_page_reader.sv
// Directed bench for tdc_page_reader with a behavioural DPRAM and a stream scoreboard.
`timescale 1ns/1ps
module tb_tdc_page_reader;
    import tdc_ram_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int SYNC_STAGES = 2;

    logic              SYSCLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              handshakeFPGA = 1'b0;
    logic              handshakePC;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic [31:0]       page_count;
    logic              err_len;
    logic [2:0]        dbg_state;

    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    logic              last_q [$];

    int checks = 0;
    int errors = 0;
    int stall_viol = 0;
    int bubbles = 0;
    int err_pulses = 0;

    tdc_page_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RESET_N       (RESET_N),
        .handshakeFPGA (handshakeFPGA),
        .handshakePC   (handshakePC),
        .ram_addr      (ram_addr),
        .ram_re        (ram_re),
        .ram_rdata     (ram_rdata),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .page_count    (page_count),
        .err_len       (err_len),
        .dbg_state     (dbg_state)
    );

    // clock / memory model
    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always @(negedge SYSCLK) begin
        if (err_len === 1'b1) err_pulses++;
    end

    // driver tasks
    task automatic load_page(input logic [DATA_W-1:0] hdr, input int n, input logic [DATA_W-1:0] base);
        mem[0] = hdr;
        exp_q.delete();
        for (int i = 1; i <= n; i++) begin
            mem[i] = base + DATA_W'(i);
            exp_q.push_back(base + DATA_W'(i));
        end
    endtask

    task automatic collect_page(input int max_cycles, input bit rnd, input int stop_words);
        bit stalled, done, seen;
        logic [DATA_W-1:0] sd;
        logic sl;
        stalled = 0; done = 0; seen = 0; sd = '0; sl = 1'b0;
        stall_viol = 0; bubbles = 0;
        got_q.delete(); last_q.delete();
        for (int c = 0; c < max_cycles && !done; c++) begin
            if (stalled && (out_valid !== 1'b1 || out_data !== sd || out_last !== sl)) stall_viol++;
            if (seen && out_valid !== 1'b1) bubbles++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (out_valid === 1'b1) begin
                seen = 1;
                if (out_ready) begin
                    got_q.push_back(out_data);
                    last_q.push_back(out_last);
                    if (out_last === 1'b1 || (stop_words != 0 && got_q.size() == stop_words)) done = 1;
                end else begin
                    stalled = 1; sd = out_data; sl = out_last;
                end
            end
            @(negedge SYSCLK);
        end
        out_ready = 1'b1;
    endtask

    task automatic end_page(output int cyc);
        handshakeFPGA = 1'b0;
        cyc = 0;
        while (handshakePC === 1'b1 && cyc < 20) begin
            @(negedge SYSCLK);
            cyc++;
        end
        repeat (2) @(negedge SYSCLK);
    endtask

    // scenarios
    task automatic test_reset();
        RESET_N = 1'b0; handshakeFPGA = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge SYSCLK);
        checks++; if (handshakePC !== 1'b0) begin errors++; $display("FAIL reset_hspc got %b want 0", handshakePC); end
        checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_valid_last got %b%b want 00", out_valid, out_last); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (page_count !== 32'd0) begin errors++; $display("FAIL reset_page_count got %h want 0", page_count); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got %b want 0", err_len); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
        RESET_N = 1'b1;
        @(negedge SYSCLK);
    endtask

    task automatic test_basic();
        int cyc, e0;
        e0 = err_pulses;
        load_page(32'd4, 4, 32'hA0);
        handshakeFPGA = 1'b1;
        repeat (2) @(negedge SYSCLK);
        checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL basic_re_early got %b want 0", ram_re); end
        @(negedge SYSCLK);
        checks++; if (ram_re !== 1'b1 || ram_addr !== '0) begin errors++; $display("FAIL basic_re_hdr got re=%b addr=%h want re=1 addr=0", ram_re, ram_addr); end
        repeat (2) @(negedge SYSCLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b want 0", out_valid); end
        @(negedge SYSCLK);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin errors++; $display("FAIL basic_first_beat got v=%b d=%h want v=1 d=a1", out_valid, out_data); end
        collect_page(50, 1'b0, 0);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== 1'(i == exp_q.size() - 1)) begin
                errors++; $display("FAIL basic_word%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL basic_bubbles got %0d want 0", bubbles); end
        checks++; if (handshakePC !== 1'b1) begin errors++; $display("FAIL basic_hspc_rise got %b want 1", handshakePC); end
        checks++; if (page_count !== 32'd1) begin errors++; $display("FAIL basic_page_count got %0d want 1", page_count); end
        checks++; if (err_pulses != e0) begin errors++; $display("FAIL basic_err_len got %0d pulses want 0", err_pulses - e0); end
        end_page(cyc);
        checks++; if (cyc >= 20) begin errors++; $display("FAIL basic_release got timeout want hspc low"); end
    endtask

    task automatic test_empty();
        bit seen_valid;
        logic pc4, pc5, pc7, pc8;
        seen_valid = 0; pc4 = 1'bx; pc5 = 1'bx; pc7 = 1'bx; pc8 = 1'bx;
        load_page(32'd0, 0, 32'h0);
        handshakeFPGA = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge SYSCLK);
            if (out_valid !== 1'b0) seen_valid = 1;
            if (c == 4) pc4 = handshakePC;
            if (c == 5) begin pc5 = handshakePC; handshakeFPGA = 1'b0; end
            if (c == 7) pc7 = handshakePC;
            if (c == 8) pc8 = handshakePC;
        end
        checks++; if (pc4 !== 1'b0) begin errors++; $display("FAIL empty_hspc_early got %b want 0", pc4); end
        checks++; if (pc5 !== 1'b1) begin errors++; $display("FAIL empty_hspc_rise got %b want 1", pc5); end
        checks++; if (pc7 !== 1'b1) begin errors++; $display("FAIL empty_hspc_hold got %b want 1", pc7); end
        checks++; if (pc8 !== 1'b0) begin errors++; $display("FAIL empty_hspc_fall got %b want 0", pc8); end
        checks++; if (seen_valid) begin errors++; $display("FAIL empty_no_valid got 1 want 0"); end
        checks++; if (page_count !== 32'd2) begin errors++; $display("FAIL empty_page_count got %0d want 2", page_count); end
    endtask

    task automatic test_stall();
        int cyc;
        load_page(32'd200, 200, 32'h3000_0000);
        handshakeFPGA = 1'b1;
        collect_page(3000, 1'b1, 0);
        checks++; if (got_q.size() != 200) begin errors++; $display("FAIL stall_count got %0d want 200", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== 1'(i == exp_q.size() - 1)) begin
                errors++; $display("FAIL stall_word%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
        end_page(cyc);
        checks++; if (cyc >= 20 || page_count !== 32'd3) begin errors++; $display("FAIL stall_done got cyc=%0d pages=%0d want <20 and 3", cyc, page_count); end
    endtask

    task automatic test_clamp();
        int cyc, e0;
        e0 = err_pulses;
        load_page(32'h1FF, 255, 32'h5500_0000);
        handshakeFPGA = 1'b1;
        collect_page(2000, 1'b0, 0);
        checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL clamp_err_len got %0d pulses want 1", err_pulses - e0); end
        checks++; if (got_q.size() != 255) begin errors++; $display("FAIL clamp_count got %0d want 255", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== 1'(i == exp_q.size() - 1)) begin
                errors++; $display("FAIL clamp_word%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL clamp_bubbles got %0d want 0", bubbles); end
        end_page(cyc);
        checks++; if (cyc >= 20 || page_count !== 32'd4) begin errors++; $display("FAIL clamp_done got cyc=%0d pages=%0d want <20 and 4", cyc, page_count); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        load_page(32'd10, 10, 32'h7700);
        handshakeFPGA = 1'b1;
        collect_page(200, 1'b0, 3);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL rmid_pre_count got %0d want 3", got_q.size()); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rmid_out got v=%b l=%b d=%h want 0", out_valid, out_last, out_data); end
        checks++; if (ram_re !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL rmid_ram got re=%b addr=%h want 0", ram_re, ram_addr); end
        checks++; if (handshakePC !== 1'b0 || page_count !== 32'd0 || err_len !== 1'b0) begin errors++; $display("FAIL rmid_ctl got pc=%b cnt=%0d err=%b want 0", handshakePC, page_count, err_len); end
        @(negedge SYSCLK);
        RESET_N = 1'b1;
        collect_page(200, 1'b0, 0);
        checks++; if (got_q.size() != 10) begin errors++; $display("FAIL rmid_count got %0d want 10", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== 1'(i == exp_q.size() - 1)) begin
                errors++; $display("FAIL rmid_word%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        end_page(cyc);
        checks++; if (cyc >= 20 || page_count !== 32'd1) begin errors++; $display("FAIL rmid_done got cyc=%0d pages=%0d want <20 and 1", cyc, page_count); end
    endtask

    task automatic test_wrap();
        int cyc;
        force dut.page_count = 32'hFFFF_FFFF;
        @(negedge SYSCLK);
        release dut.page_count;
        load_page(32'd1, 1, 32'hC000);
        handshakeFPGA = 1'b1;
        collect_page(100, 1'b0, 0);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", got_q.size()); end
        checks++; if (got_q.size() > 0 && (got_q[0] !== 32'hC001 || last_q[0] !== 1'b1)) begin errors++; $display("FAIL wrap_word got %h/%b want c001/1", got_q[0], last_q[0]); end
        checks++; if (handshakePC !== 1'b1 || page_count !== 32'd0) begin errors++; $display("FAIL wrap_page_count got pc=%b cnt=%h want pc=1 cnt=0", handshakePC, page_count); end
        end_page(cyc);
        checks++; if (cyc >= 20) begin errors++; $display("FAIL wrap_release got timeout want hspc low"); end
    endtask

    // sequence and report
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_clamp();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
